// File: rtl/mips32_mem_wb_backend_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips32_mem_wb_backend_if                                     |
// | Description : MEM-stage control/data bundle and writeback bus of the core. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mips32_mem_wb_backend_if #(
    parameter int CNT_W = 16
);
    logic             RegWrite_MEM;
    logic             MemtoReg_MEM;
    logic             Branch_MEM;
    logic             MemRead_MEM;
    logic             MemWrite_MEM;
    logic             Zero_MEM;
    logic [31:0]      ALU_Result_MEM;
    logic [31:0]      Write_Data_MEM;
    logic [4:0]       Write_Register_MEM;
    logic             PCSrc_MEM;
    logic             RegWrite_WB;
    logic [4:0]       Write_Register_WB;
    logic [31:0]      Write_Data_WB;
    logic [CNT_W-1:0] Load_Count;
    logic [CNT_W-1:0] Store_Count;
    logic [CNT_W-1:0] Branch_Taken_Count;

    // Core side drives the MEM stage and consumes the writeback bus.
    modport master (
        output RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM,
               Zero_MEM, ALU_Result_MEM, Write_Data_MEM, Write_Register_MEM,
        input  PCSrc_MEM, RegWrite_WB, Write_Register_WB, Write_Data_WB,
               Load_Count, Store_Count, Branch_Taken_Count
    );

    modport slave (
        input  RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM,
               Zero_MEM, ALU_Result_MEM, Write_Data_MEM, Write_Register_MEM,
        output PCSrc_MEM, RegWrite_WB, Write_Register_WB, Write_Data_WB,
               Load_Count, Store_Count, Branch_Taken_Count
    );
endinterface
`default_nettype wire

// File: rtl/mips32_mem_wb_backend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips32_mem_wb_backend                                        |
// | Description : Data RAM, MEM/WB register, writeback mux, branch select and  |
// |               saturating bring-up event counters for the MIPS32 core.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips32_mem_wb_backend #(
    parameter int MEM_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    mips32_mem_wb_backend_if.slave  bus
);
    localparam int c_IDX_W = $clog2(MEM_WORDS);

    logic [31:0]        r_mem [MEM_WORDS];
    logic [31:0]        r_rd_data;
    logic               r_regwrite;
    logic               r_memtoreg;
    logic [4:0]         r_write_reg;
    logic [31:0]        r_alu_result;
    logic [CNT_W-1:0]   r_load_count;
    logic [CNT_W-1:0]   r_store_count;
    logic [CNT_W-1:0]   r_branch_count;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_branch_taken;
    logic               w_unused_addr_bits;

    // Byte offset and bits above the RAM depth are dropped: aligned, wrapping access.
    assign w_idx              = bus.ALU_Result_MEM[c_IDX_W+1:2];
    assign w_unused_addr_bits = ^{bus.ALU_Result_MEM[31:c_IDX_W+2], bus.ALU_Result_MEM[1:0]};
    assign w_branch_taken     = bus.Branch_MEM & bus.Zero_MEM;

    // Read data is registered alongside the write so a same-word collision returns old data.
    always_ff @(posedge Clk) begin
        if (bus.MemWrite_MEM && !Reset) begin
            r_mem[w_idx] <= bus.Write_Data_MEM;
        end
        r_rd_data <= r_mem[w_idx];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_regwrite     <= 1'b0;
            r_memtoreg     <= 1'b0;
            r_write_reg    <= 5'd0;
            r_alu_result   <= 32'd0;
            r_load_count   <= '0;
            r_store_count  <= '0;
            r_branch_count <= '0;
        end else begin
            r_regwrite   <= bus.RegWrite_MEM;
            r_memtoreg   <= bus.MemtoReg_MEM;
            r_write_reg  <= bus.Write_Register_MEM;
            r_alu_result <= bus.ALU_Result_MEM;
            if (bus.MemRead_MEM && (r_load_count != {CNT_W{1'b1}})) begin
                r_load_count <= r_load_count + 1'b1;
            end
            if (bus.MemWrite_MEM && (r_store_count != {CNT_W{1'b1}})) begin
                r_store_count <= r_store_count + 1'b1;
            end
            if (w_branch_taken && (r_branch_count != {CNT_W{1'b1}})) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
        end
    end

    assign bus.PCSrc_MEM          = w_branch_taken & ~Reset;
    assign bus.RegWrite_WB        = r_regwrite & (r_write_reg != 5'd0);
    assign bus.Write_Register_WB  = r_write_reg;
    assign bus.Write_Data_WB      = r_memtoreg ? r_rd_data : r_alu_result;
    assign bus.Load_Count         = r_load_count;
    assign bus.Store_Count        = r_store_count;
    assign bus.Branch_Taken_Count = r_branch_count;
endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_wb_backend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips32_mem_wb_backend                                     |
// | Description : Directed self-checking bench for mips32_mem_wb_backend.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips32_mem_wb_backend;
    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_fail;

    mips32_mem_wb_backend_if #(.CNT_W(16)) bus   ();
    mips32_mem_wb_backend_if #(.CNT_W(4))  bus_s ();

    mips32_mem_wb_backend #(.MEM_WORDS(256), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    mips32_mem_wb_backend #(.MEM_WORDS(256), .CNT_W(4)) dut_sat (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_s)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic br, input logic mr,
                         input logic mw, input logic z, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] wr);
        bus.RegWrite_MEM       = rw;
        bus.MemtoReg_MEM       = m2r;
        bus.Branch_MEM         = br;
        bus.MemRead_MEM        = mr;
        bus.MemWrite_MEM       = mw;
        bus.Zero_MEM           = z;
        bus.ALU_Result_MEM     = alu;
        bus.Write_Data_MEM     = wd;
        bus.Write_Register_MEM = wr;
    endtask

    task automatic edge_wait();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus_s.RegWrite_MEM = 0; bus_s.MemtoReg_MEM = 0; bus_s.Branch_MEM = 0;
        bus_s.MemRead_MEM  = 0; bus_s.MemWrite_MEM = 0; bus_s.Zero_MEM   = 0;
        bus_s.ALU_Result_MEM = 0; bus_s.Write_Data_MEM = 0; bus_s.Write_Register_MEM = 0;

        // Reset held two cycles with a store that must be discarded
        Reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        edge_wait();
        edge_wait();
        chk("rst_regwrite",  {31'd0, bus.RegWrite_WB}, 32'd0);
        chk("rst_wreg",      {27'd0, bus.Write_Register_WB}, 32'd0);
        chk("rst_wdata",     bus.Write_Data_WB, 32'd0);
        chk("rst_loadcnt",   {16'd0, bus.Load_Count}, 32'd0);
        chk("rst_storecnt",  {16'd0, bus.Store_Count}, 32'd0);
        chk("rst_brcnt",     {16'd0, bus.Branch_Taken_Count}, 32'd0);
        chk("rst_pcsrc",     {31'd0, bus.PCSrc_MEM}, 32'd0);

        // Store then load from an unaligned address in the same word
        Reset = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 32'h40, 32'h12345678, 5'd0);
        edge_wait();
        drive(1, 1, 0, 1, 0, 0, 32'h43, 32'h0, 5'd5);
        edge_wait();
        chk("ld_wdata",    bus.Write_Data_WB, 32'h12345678);
        chk("ld_wreg",     {27'd0, bus.Write_Register_WB}, 32'd5);
        chk("ld_regwrite", {31'd0, bus.RegWrite_WB}, 32'd1);
        chk("ld_loadcnt",  {16'd0, bus.Load_Count}, 32'd1);
        chk("ld_storecnt", {16'd0, bus.Store_Count}, 32'd1);

        // The store issued during reset must not have landed
        drive(1, 1, 0, 1, 0, 0, 32'h10, 32'h0, 5'd3);
        edge_wait();
        n_cmp++;
        assert (bus.Write_Data_WB !== 32'hDEADBEEF)
        else begin
            n_fail++;
            $error("FAIL rst_store_discard observed=0x%08h expected=not 0xdeadbeef", bus.Write_Data_WB);
        end
        chk("ld2_loadcnt", {16'd0, bus.Load_Count}, 32'd2);

        // ALU writeback, then a write to $0 that must be suppressed
        drive(1, 0, 0, 0, 0, 0, 32'hCAFE0001, 32'h0, 5'd9);
        edge_wait();
        chk("alu_wdata",    bus.Write_Data_WB, 32'hCAFE0001);
        chk("alu_regwrite", {31'd0, bus.RegWrite_WB}, 32'd1);
        chk("alu_wreg",     {27'd0, bus.Write_Register_WB}, 32'd9);
        drive(1, 0, 0, 0, 0, 0, 32'h00000077, 32'h0, 5'd0);
        edge_wait();
        chk("r0_regwrite",  {31'd0, bus.RegWrite_WB}, 32'd0);
        chk("r0_wdata",     bus.Write_Data_WB, 32'h77);

        // 0x400 aliases word 0 in a 256-word RAM
        drive(0, 0, 0, 0, 1, 0, 32'h400, 32'hA5A5A5A5, 5'd0);
        edge_wait();
        drive(1, 1, 0, 1, 0, 0, 32'h0, 32'h0, 5'd7);
        edge_wait();
        chk("wrap_wdata",    bus.Write_Data_WB, 32'hA5A5A5A5);
        chk("wrap_storecnt", {16'd0, bus.Store_Count}, 32'd2);
        chk("wrap_loadcnt",  {16'd0, bus.Load_Count}, 32'd3);

        // Branch select: taken, not taken, taken under reset
        drive(0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 5'd0);
        #1;
        chk("br_pcsrc_t", {31'd0, bus.PCSrc_MEM}, 32'd1);
        edge_wait();
        chk("br_cnt_1", {16'd0, bus.Branch_Taken_Count}, 32'd1);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        chk("br_pcsrc_nt", {31'd0, bus.PCSrc_MEM}, 32'd0);
        edge_wait();
        chk("br_cnt_hold", {16'd0, bus.Branch_Taken_Count}, 32'd1);
        drive(1, 0, 1, 0, 0, 1, 32'h123, 32'h0, 5'd6);
        Reset = 1'b1;
        #1;
        chk("br_pcsrc_rst", {31'd0, bus.PCSrc_MEM}, 32'd0);
        edge_wait();
        chk("br_cnt_rst",   {16'd0, bus.Branch_Taken_Count}, 32'd0);
        chk("midrst_rw",    {31'd0, bus.RegWrite_WB}, 32'd0);
        chk("midrst_ldcnt", {16'd0, bus.Load_Count}, 32'd0);

        // First instruction after reset deasserts is processed normally
        Reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 32'h00000055, 32'h0, 5'd4);
        edge_wait();
        chk("post_rst_wdata", bus.Write_Data_WB, 32'h55);
        chk("post_rst_rw",    {31'd0, bus.RegWrite_WB}, 32'd1);
        chk("post_rst_wreg",  {27'd0, bus.Write_Register_WB}, 32'd4);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

        // 4-bit store counter saturates at 15
        chk("sat_start", {28'd0, bus_s.Store_Count}, 32'd0);
        bus_s.MemWrite_MEM = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            bus_s.ALU_Result_MEM = 32'(n * 4);
            bus_s.Write_Data_MEM = 32'(n);
            edge_wait();
            chk($sformatf("sat_store_count_%0d", n), {28'd0, bus_s.Store_Count},
                (n >= 15) ? 32'd15 : 32'(n));
        end
        bus_s.MemWrite_MEM = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mips32_mem_wb_backend.md
# mips32_mem_wb_backend

Back end of the MIPS32 pipeline: it takes the MEM-stage control and data outputs of the core, performs the data-memory access in a synchronous word-addressed RAM, registers the MEM/WB stage, and drives the writeback bus (`Write_Register_WB`, `Write_Data_WB`, `RegWrite_WB`) and the branch select `PCSrc_MEM` back into the core. It closes the loop that the core leaves open at its MEM/WB boundary. It also keeps three saturating event counters for bring-up.

## Interface
Parameters:
- `MEM_WORDS`, default 256: data memory depth in 32-bit words; must be a power of two.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `RegWrite_MEM` in 1: instruction in MEM writes the register file.
- `MemtoReg_MEM` in 1: writeback source is load data (1) or ALU result (0).
- `Branch_MEM` in 1: instruction in MEM is a branch.
- `MemRead_MEM` in 1: load.
- `MemWrite_MEM` in 1: store.
- `Zero_MEM` in 1: ALU zero flag.
- `ALU_Result_MEM` in 32: byte address for loads and stores, otherwise the writeback value.
- `Write_Data_MEM` in 32: store data. This is the full rt value.
- `Write_Register_MEM` in 5: destination register.
- `PCSrc_MEM` out 1: take the branch.
- `RegWrite_WB` out 1: register-file write enable.
- `Write_Register_WB` out 5: register-file write address.
- `Write_Data_WB` out 32: register-file write data.
- `Load_Count` out CNT_W: loads retired.
- `Store_Count` out CNT_W: stores performed.
- `Branch_Taken_Count` out CNT_W: taken branches.

## Operation
- **Word index.** The index is `ALU_Result_MEM[log2(MEM_WORDS)+1:2]`.
  - Bits [1:0] are ignored, so access is word-aligned.
  - Upper bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- **Store.** At the edge where `MemWrite_MEM=1` and `Reset=0`, `Write_Data_MEM` is written to the indexed word.
  - The memory is not cleared by reset. Its contents are undefined until written.
- **Load.** The read port is synchronous. The index is registered at the edge, and the RAM data is valid during the following (WB) cycle.
  - The read is performed every cycle regardless of `MemRead_MEM`.
  - If the same word is read and written at the same edge, the read returns the old data. A single instruction never does both.
- **MEM/WB register.** At each edge it captures `RegWrite_MEM`, `MemtoReg_MEM` and `Write_Register_MEM`, plus `ALU_Result_MEM` into `ALU_Result_WB`.
- **Writeback mux.** `Write_Data_WB = MemtoReg_WB ? RAM read data : ALU_Result_WB`. It is combinational from registered values.
- **Register 0.** `RegWrite_WB = RegWrite_q & (Write_Register_WB != 0)`. Writes to $0 are suppressed.
- **Branch select.** `PCSrc_MEM = Branch_MEM & Zero_MEM & ~Reset`. It is combinational and has no register.
- **Counters.** Each counter increments by 1 at an edge where its event holds, and saturates at all-ones (no wrap).
  - `Load_Count` event: `MemRead_MEM`.
  - `Store_Count` event: `MemWrite_MEM`.
  - `Branch_Taken_Count` event: `Branch_MEM & Zero_MEM`.
- **Reset.** At any edge with `Reset=1`:
  - the MEM/WB register is cleared (RegWrite 0, MemtoReg 0, register 0, ALU result 0);
  - all counters are cleared to 0;
  - a store presented in that cycle is discarded;
  - events in that cycle are not counted.

## Timing
- **Reset values (cycle after a reset edge):**
  - `RegWrite_WB=0`, `Write_Register_WB=0`, `Write_Data_WB=0`;
  - all counters 0;
  - `PCSrc_MEM=0` while `Reset` is high.
- **Latency.**
  - MEM inputs at edge k appear on the WB outputs during cycle k+1.
  - The core's register file commits them at edge k+1.
  - Total MEM-to-regfile latency is 2 edges.
- **Store then load.** A store at edge k followed by a load of the same word at edge k+1 returns the new data in cycle k+2. There is no bypass requirement.
- **`PCSrc_MEM` timing.** It is valid in the same cycle as the MEM inputs, before the edge.
- **Back-to-back operation.** One instruction is accepted per cycle with no stall and no handshake. Each instruction is presented for exactly one cycle.
- **Reset mid-stream.** An instruction in MEM during a reset edge is lost. The instruction presented at the first edge after reset deasserts is processed normally.
- **Counter saturation.** When a counter is at all-ones and its event occurs, it holds at all-ones.

## Test plan
- **Reset.**
  - Stimulus: assert `Reset` for 2 cycles with `MemWrite_MEM=1`, `ALU_Result_MEM=0x10`, `Write_Data_MEM=0xDEADBEEF`.
  - Required: all outputs 0 and counters 0. A later load of 0x10 must not return 0xDEADBEEF unless 0xDEADBEEF was already stored there before reset.
- **Store then load.**
  - Stimulus: store 0x12345678 to 0x40, then load 0x43 with `RegWrite_MEM=1`, `MemtoReg_MEM=1`, destination 5.
  - Required: cycle after the load, `Write_Data_WB=0x12345678`, `Write_Register_WB=5`, `RegWrite_WB=1`, `Load_Count=1`, `Store_Count=1`.
- **ALU writeback.**
  - Stimulus: `ALU_Result_MEM=0xCAFE0001`, `MemtoReg_MEM=0`, destination 9; next cycle, destination 0 with `RegWrite_MEM=1`.
  - Required: `Write_Data_WB=0xCAFE0001` with `RegWrite_WB=1`, then `RegWrite_WB=0`.
- **Address wrap.**
  - Stimulus: with `MEM_WORDS=256`, store 0xA5A5A5A5 to 0x400, then load 0x000.
  - Required: the load returns 0xA5A5A5A5.
- **Branch select.**
  - Stimulus: `Branch_MEM=1` with `Zero_MEM` = 1, then 0, then 1 with `Reset=1`.
  - Required: `PCSrc_MEM` = 1, 0, 0. `Branch_Taken_Count` is 1 after the first edge and 0 after the reset edge.
- **Saturation.**
  - Stimulus: with `CNT_W=4`, hold `MemWrite_MEM=1` for 20 cycles.
  - Required: `Store_Count` reaches 15 at edge 15 and stays at 15.
